cci_rd_rob: RTL
===============

Name: cci_rd_rob

Overview:
- Read-response reorder buffer between the CCI-P c0 read-response path (Rx) and the AFU compute/write stage.
- Hands out mdata tags to the read-request generator.
- Absorbs out-of-order eRSP_RDLINE responses and delivers line data strictly in request order, each line with its sequence index.
- The downstream write stage can then compute the destination address from the index and no longer needs any mdata-offset arithmetic.

Parameters:
- DEPTH, 64, number of outstanding lines; power of 2, range 4..512.
- DATA_WIDTH, 512, cache-line width (t_ccip_clData).
- IDX_WIDTH, 32, width of the line sequence index.

Ports:
- Clk  in  1  clock.
- Resetb  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all pointers and entries (asserted while the AFU is in IDLE).
- alloc_req  in  1  request generator wants a tag this cycle.
- alloc_gnt  out  1  tag granted; combinational from registered count.
- alloc_tag  out  16  mdata to place in the read header; upper bits are 0.
- rsp_valid  in  1  c0 read response valid (rspValid and eRSP_RDLINE and eCL_LEN_1).
- rsp_tag  in  16  mdata of the response.
- rsp_data  in  DATA_WIDTH  response payload.
- out_valid  out  1  in-order line available.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_WIDTH  line payload.
- out_idx  out  IDX_WIDTH  sequence number of the line since the last flush.
- count  out  $clog2(DEPTH)+1  allocated entries.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (Resetb=0, asynchronous):
  - head, tail, count, seq all 0; all entry-valid bits 0.
  - out_valid=0, out_data=0, out_idx=0, err=0.
  - Reset mid-operation drops all in-flight state. Responses arriving after reset for stale tags set err.
- flush=1: same clearing as reset on the next edge. flush has priority over all other inputs that cycle.
- Allocation:
  - alloc_gnt = alloc_req && count<DEPTH, evaluated on registered count.
  - A pop in the same cycle does not free a slot for that cycle's grant.
  - On grant: alloc_tag = tail; tail <= tail+1 (mod DEPTH); entry[tail].alloc <= 1.
- Response:
  - If rsp_valid and entry[rsp_tag mod DEPTH] is allocated and not yet filled: store data, set filled.
  - If rsp_tag >= DEPTH, the slot is unallocated, or the slot is already filled: drop the response and set err.
- Pop:
  - Output register is loaded when entry[head].filled && (!out_valid || out_ready).
  - On load: out_data <= entry data, out_idx <= seq, seq <= seq+1, head <= head+1, clear alloc/filled of the slot.
  - out_valid holds with stable data until out_ready.
  - out_ready while !out_valid is ignored.
- Latency: a response for tag==head with the output register free gives out_valid two edges after the rsp_valid edge (edge 1 writes the array, edge 2 reads into the output register). Sustained throughput is 1 line/cycle when responses are in order and out_ready=1.
- Simultaneous events:
  - A response to head arriving in the same cycle as a pop of the previous line is legal.
  - Grant plus pop in one cycle: count unchanged.
  - Response plus grant to the same slot cannot occur because the slot is still allocated.
- Wrap-around:
  - Tags wrap modulo DEPTH.
  - seq wraps at 2^IDX_WIDTH with no error.
  - count never exceeds DEPTH.
- Storage: data array is a simple dual-port RAM (1 write port, 1 read port), inferable as M20K.
- Pointers and control bits are flops.

Decomposition:
- Shared package cci_rd_rob_pkg: t_rob_tag, t_rob_entry_ctl (alloc, filled), default DEPTH constant.
- Data storage in one sub-module rob_sdp_ram (DEPTH x DATA_WIDTH, registered read, async-reset-free).

Test Plan:
- DEPTH=4, in-order: grant tags 0,1,2,3, return responses 0..3 with data 0xA0..0xA3, out_ready=1. Expect out_idx 0..3 with matching data, first out_valid 2 edges after rsp 0, count ends at 0.
- Reverse order: allocate 4, return tags 3,2,1,0. Expect no out_valid until tag 0 lands, then idx 0..3 on 4 consecutive cycles, data in order.
- Full/backpressure: allocate 4 with alloc_req still high. Expect alloc_gnt=0 while count=4. Hold out_ready=0 after responses and expect out_data stable; release and expect grant again one cycle after the first pop.
- Errors: send a response with tag 2 while unallocated, then a duplicate response for tag 0. Expect err=1 sticky, no out_valid, count unchanged.
- Mid-operation: allocate 3, return tag 1, assert Resetb=0 for 1 cycle. Expect count=0, out_valid=0 immediately. A response with tag 0 afterwards sets err. A new allocation returns tag 0 with out_idx restarting at 0.
- Wrap: DEPTH=4, stream 10 lines with random 0-3 cycle response delays. Expect out_idx 0..9 in order, and tags reused 0,1,2,3,0,... with no err.

Source files
------------

// File: rtl/cci_rd_rob_pkg.sv
// Shared types and defaults for the CCI-P read-response reorder buffer.
//   t_rob_tag       : mdata tag as carried in the c0 request/response headers
//   t_rob_entry_ctl : per-slot control bits (alloc, filled)
//   ROB_DEPTH       : default number of outstanding lines
package cci_rd_rob_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int ROB_TAG_W = 16;

  typedef logic [ROB_TAG_W-1:0] t_rob_tag;

  typedef struct packed {
    logic alloc;   // tag handed to the request generator, line not yet delivered
    logic filled;  // response data has landed in the data array
  } t_rob_entry_ctl;

  // A response tag addresses a real slot only when it is below the depth;
  // larger tags would silently alias onto a slot if only the low bits were used.
  function automatic logic tag_in_range(input t_rob_tag tag, input int unsigned depth);
    return (32'(tag) < depth);
  endfunction

endpackage

// File: rtl/cci_rd_rob_ram.sv
// Simple dual-port line storage for the reorder buffer: one write port, one
// registered read port, no reset so it maps onto block RAM.
//   clk   : clock
//   we    : write enable, waddr/wdata : write port
//   re    : read enable, raddr : read address
//   rdata : registered read data, holds its value while re is low
module rob_sdp_ram #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 512,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; the register is only updated on a read so it doubles as the output hold
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/cci_rd_rob.sv
// Read-response reorder buffer between the CCI-P c0 Rx read-response path and
// the AFU write stage. Hands out mdata tags, absorbs out-of-order responses and
// delivers lines strictly in request order together with their sequence index.
//   Clk, Resetb          : clock, asynchronous active-low reset
//   flush                : synchronous clear of all state (priority over all inputs)
//   alloc_req/gnt/tag    : tag allocation towards the read-request generator
//   rsp_valid/tag/data   : c0 read-line responses
//   out_valid/ready/data : in-order line stream, out_idx = index since last flush
//   count                : allocated entries (including the one being moved out)
//   err                  : sticky protocol error (bad, stale or duplicate tag)
module cci_rd_rob
  import cci_rd_rob_pkg::*;
#(
  parameter int DEPTH      = ROB_DEPTH,
  parameter int DATA_WIDTH = 512,
  parameter int IDX_WIDTH  = 32
) (
  input  logic                   Clk,
  input  logic                   Resetb,
  input  logic                   flush,
  input  logic                   alloc_req,
  output logic                   alloc_gnt,
  output logic [15:0]            alloc_tag,
  input  logic                   rsp_valid,
  input  logic [15:0]            rsp_tag,
  input  logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [IDX_WIDTH-1:0]   out_idx,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         head_r;
  logic [AW-1:0]         tail_r;
  logic [CW-1:0]         count_r;
  logic [IDX_WIDTH-1:0]  seq_r;
  logic [IDX_WIDTH-1:0]  out_idx_r;
  logic                  out_valid_r;
  logic                  err_r;
  t_rob_entry_ctl        ctl_r [DEPTH];

  logic                  gnt_s;
  logic [AW-1:0]         rsp_slot_s;
  logic                  rsp_ok_s;
  logic                  rsp_err_s;
  logic                  load_s;
  logic [DATA_WIDTH-1:0] ram_rdata_s;

  // Grant, response classification and output-register load decision
  always_comb begin
    gnt_s      = alloc_req && (count_r < CW'(DEPTH));
    rsp_slot_s = rsp_tag[AW-1:0];
    rsp_ok_s   = 1'b0;
    rsp_err_s  = 1'b0;
    if (rsp_valid) begin
      if (tag_in_range(t_rob_tag'(rsp_tag), DEPTH) &&
          ctl_r[rsp_slot_s].alloc && !ctl_r[rsp_slot_s].filled) begin
        rsp_ok_s = 1'b1;
      end else begin
        rsp_err_s = 1'b1;
      end
    end else begin
      rsp_ok_s  = 1'b0;
      rsp_err_s = 1'b0;
    end
    // The head slot only reads as filled one edge after its data was written,
    // so the RAM read below never races the write of the same line.
    load_s = ctl_r[head_r].filled && (!out_valid_r || out_ready);
  end

  // Pointers, occupancy, sequence index, output handshake and sticky error
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      seq_r       <= '0;
      out_idx_r   <= '0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else if (flush) begin
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      seq_r       <= '0;
      out_idx_r   <= '0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (gnt_s) begin
        tail_r <= tail_r + AW'(1);
      end
      if (load_s) begin
        head_r      <= head_r + AW'(1);
        seq_r       <= seq_r + IDX_WIDTH'(1);
        out_idx_r   <= seq_r;
        out_valid_r <= 1'b1;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
      // Grant is based on the registered count, so grant plus load leaves it unchanged
      case ({gnt_s, load_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (rsp_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Per-slot control bits; grant, fill and release always target different slots
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctl_r[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctl_r[i] <= '0;
      end
    end else begin
      if (gnt_s) begin
        ctl_r[tail_r].alloc <= 1'b1;
      end
      if (rsp_ok_s) begin
        ctl_r[rsp_slot_s].filled <= 1'b1;
      end
      if (load_s) begin
        ctl_r[head_r] <= '0;
      end
    end
  end

  rob_sdp_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (Clk),
    .we    (rsp_ok_s && !flush),
    .waddr (rsp_slot_s),
    .wdata (rsp_data),
    .re    (load_s && !flush),
    .raddr (head_r),
    .rdata (ram_rdata_s)
  );

  // The RAM read register has no reset; masking with out_valid gives a clean zero after reset/flush
  assign out_data  = ram_rdata_s & {DATA_WIDTH{out_valid_r}};
  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign alloc_gnt = gnt_s;
  assign alloc_tag = 16'(tail_r);
  assign count     = count_r;
  assign err       = err_r;

endmodule
